// File: rtl/sram_stream_reader_if.sv
// ============================================================================
// sram_stream_reader_if : SRAM read port plus Avalon-ST source bundle
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface sram_stream_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   sram_address;
  logic                sram_chipselect;
  logic                sram_write;
  logic [DATA_W/8-1:0] sram_byteenable;
  logic                sram_clken;
  logic [DATA_W-1:0]   sram_readdata;

  logic [DATA_W-1:0]   src_data;
  logic                src_valid;
  logic                src_ready;
  logic                src_startofpacket;
  logic                src_endofpacket;

  modport master (
    output sram_address, sram_chipselect, sram_write, sram_byteenable, sram_clken,
    input  sram_readdata,
    output src_data, src_valid, src_startofpacket, src_endofpacket,
    input  src_ready
  );

  modport slave (
    input  sram_address, sram_chipselect, sram_write, sram_byteenable, sram_clken,
    output sram_readdata,
    input  src_data, src_valid, src_startofpacket, src_endofpacket,
    output src_ready
  );
endinterface

`default_nettype wire

// File: rtl/sram_stream_reader.sv
// ============================================================================
// sram_stream_reader : sequential SRAM reads presented as one Avalon-ST packet
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_stream_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_busy,
  output logic              o_done,
  sram_stream_reader_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_busy;
  logic              r_done;

  logic              r_inflight;
  logic              r_inf_sop;
  logic              r_inf_eop;

  logic [DATA_W-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_sop;
  logic [1:0]        r_fifo_eop;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_flush;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_drain_done;

  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid & bus.src_ready;
  assign w_flush = i_abort & (r_state != S_IDLE);
  assign w_push  = r_inflight & ~w_flush;

  // Occupancy the FIFO would reach if nothing new were issued this cycle;
  // an issue is allowed only when that leaves room for the returning word.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_RUN) && !i_abort &&
                   (r_remaining != '0) && (w_occ < 3'd2);

  assign w_drain_done = (r_state == S_DRAIN) && !r_inflight &&
                        (r_count == {1'b0, w_pop});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_inflight  <= 1'b0;
      r_inf_sop   <= 1'b0;
      r_inf_eop   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
        r_inf_sop   <= (r_remaining == r_len);
        r_inf_eop   <= (r_remaining == LEN_W'(1));
      end

      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            if (i_length != '0) begin
              r_addr      <= i_base_addr;
              r_len       <= i_length;
              r_remaining <= i_length;
              r_busy      <= 1'b1;
              r_state     <= S_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_issue && (r_remaining == LEN_W'(1))) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_drain_done) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_sop <= '0;
      r_fifo_eop <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else if (w_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_sop[r_wr_ptr] <= r_inf_sop;
        r_fifo_eop[r_wr_ptr] <= r_inf_eop;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Payload storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.sram_readdata;
    end
  end

  assign bus.sram_address      = r_addr;
  assign bus.sram_chipselect   = w_issue;
  assign bus.sram_write        = 1'b0;
  assign bus.sram_byteenable   = '1;
  assign bus.sram_clken        = 1'b1;

  assign bus.src_valid         = w_valid;
  assign bus.src_data          = r_fifo_data[r_rd_ptr];
  assign bus.src_startofpacket = w_valid & r_fifo_sop[r_rd_ptr];
  assign bus.src_endofpacket   = w_valid & r_fifo_eop[r_rd_ptr];

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
// ============================================================================
// tb_sram_stream_reader : directed self-checking bench for sram_stream_reader
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_stream_reader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 11;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic              abort   = 1'b0;
  logic [ADDR_W-1:0] base    = '0;
  logic [LEN_W-1:0]  length  = '0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_q    = '0;

  int n_checks = 0;
  int n_errors = 0;

  sram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_base_addr (base),
    .i_length    (length),
    .o_busy      (busy),
    .o_done      (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [9:0] a);
    return {22'd0, a} * 32'h01010101;
  endfunction

  // SRAM model with one-cycle read latency
  always @(posedge clk) begin
    if (bus.sram_chipselect) rd_q <= pat(bus.sram_address);
  end
  assign bus.sram_readdata = rd_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_cs"},   32'(bus.sram_chipselect), 0);
    check({tag, "_addr"}, 32'(bus.sram_address), 0);
    check({tag, "_valid"}, 32'(bus.src_valid), 0);
    check({tag, "_sop"},  32'(bus.src_startofpacket), 0);
    check({tag, "_eop"},  32'(bus.src_endofpacket), 0);
  endtask

  task automatic run_packet(input int b, input int n, input bit rnd, input int exp_done_k);
    int acc = 0, issued = 0, done_k = -1;
    int first_cs_k = -1, last_cs_k = -1, first_valid_k = -1;
    int busy_err = 0, occ_err = 0, stab_err = 0;
    bit stall = 1'b0, pop, done_seen = 1'b0;
    logic [31:0] s_data = '0;
    logic s_sop = 1'b0, s_eop = 1'b0;

    @(negedge clk);
    start = 1'b1; base = ADDR_W'(b); length = LEN_W'(n); bus.src_ready = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = 1'b0;
      bus.src_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (done) begin
        done_k = k;
        done_seen = 1'b1;
        check("busy_at_done", 32'(busy), 0);
        check("valid_at_done", 32'(bus.src_valid), 0);
        break;
      end
      if (busy !== (n > 0)) busy_err++;
      if (stall && !(bus.src_valid && bus.src_data == s_data &&
                     bus.src_startofpacket == s_sop && bus.src_endofpacket == s_eop))
        stab_err++;
      if (bus.sram_chipselect) begin
        check("addr", 32'(bus.sram_address), 32'((b + issued) % 1024));
        if (first_cs_k < 0) first_cs_k = k;
        last_cs_k = k;
        issued++;
      end
      if (bus.src_valid && first_valid_k < 0) first_valid_k = k;
      pop = bus.src_valid && bus.src_ready;
      if (issued - acc - int'(pop) > 2) occ_err++;
      if (pop) begin
        check("data", bus.src_data, pat(10'((b + acc) % 1024)));
        check("sop", 32'(bus.src_startofpacket), 32'(acc == 0));
        check("eop", 32'(bus.src_endofpacket), 32'(acc == n - 1));
        acc++;
      end
      stall = bus.src_valid && !bus.src_ready;
      s_data = bus.src_data;
      s_sop = bus.src_startofpacket;
      s_eop = bus.src_endofpacket;
    end
    check("done_seen", 32'(done_seen), 1);
    if (exp_done_k >= 0) check("done_latency", 32'(done_k), 32'(exp_done_k));
    check("beats", 32'(acc), 32'(n));
    check("strobes", 32'(issued), 32'(n));
    check("busy_during", 32'(busy_err), 0);
    check("outstanding", 32'(occ_err), 0);
    check("stall_stable", 32'(stab_err), 0);
    if (!rnd && n > 0) begin
      check("first_strobe", 32'(first_cs_k), 1);
      check("last_strobe", 32'(last_cs_k), 32'(n));
      check("first_valid", 32'(first_valid_k), 3);
    end
    @(negedge clk);
    #1;
    check("done_width", 32'(done), 0);
  endtask

  typedef struct {
    int base;
    int len;
    bit rnd;
    int exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit found;
    int acc;
    int late_err;

    vecs[0] = '{base: 0,    len: 4,  rnd: 1'b0, exp_done: 7};
    vecs[1] = '{base: 1022, len: 4,  rnd: 1'b0, exp_done: 7};
    vecs[2] = '{base: 1,    len: 1,  rnd: 1'b0, exp_done: 4};
    vecs[3] = '{base: 5,    len: 0,  rnd: 1'b0, exp_done: 1};
    vecs[4] = '{base: 100,  len: 16, rnd: 1'b1, exp_done: -1};
    vecs[5] = '{base: 1020, len: 8,  rnd: 1'b0, exp_done: 11};

    bus.src_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("tie_write", 32'(bus.sram_write), 0);
    check("tie_be", 32'(bus.sram_byteenable), 32'hf);
    check("tie_clken", 32'(bus.sram_clken), 1);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_packet(vecs[i].base, vecs[i].len, vecs[i].rnd, vecs[i].exp_done);

    // Abort while beat 5 of 16 is on the bus
    found = 1'b0;
    acc = 0;
    @(negedge clk);
    start = 1'b1; base = 10'd200; length = 11'd16; bus.src_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (bus.src_valid && bus.src_ready) begin
        if (acc == 5) begin
          abort = 1'b1;
          found = 1'b1;
          break;
        end
        acc++;
      end
    end
    check("abort_reached", 32'(found), 1);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_valid", 32'(bus.src_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_cs", 32'(bus.sram_chipselect), 0);
    late_err = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (done || bus.src_valid || busy) late_err++;
    end
    check("abort_quiet", 32'(late_err), 0);
    run_packet(300, 5, 1'b0, 8);

    // Asynchronous reset in the middle of a packet
    @(negedge clk);
    start = 1'b1; base = 10'd50; length = 11'd16; bus.src_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("prerst_valid", 32'(bus.src_valid), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    run_packet(7, 3, 1'b0, 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_stream_reader.md
# sram_stream_reader

Streaming read engine that sits directly downstream of the 1024 x 32 on-chip SRAM. On a start command it issues sequential single-word reads on the SRAM's port, absorbs the SRAM's fixed 1-cycle read latency in a 2-entry skid FIFO, and presents the words as an Avalon-ST packet with valid/ready backpressure. It sustains one word per cycle when the sink holds ready high.

## Interface
- ADDR_W, 10, SRAM word-address width; depth is 2^ADDR_W words
- DATA_W, 32, SRAM and stream data width
- LEN_W, 11, length field width; must hold 2^ADDR_W
- clk  in  1  single clock; all logic rises on clk
- reset_n  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronised by the system reset controller
- start  in  1  one-cycle command pulse; sampled only in IDLE
- abort  in  1  synchronous cancel of the current packet
- base_addr  in  ADDR_W  first word address; sampled with start
- length  in  LEN_W  number of words, 0..1024; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last beat is accepted by the sink
- sram_address  out  ADDR_W  read address
- sram_chipselect  out  1  read strobe; one word per cycle it is high
- sram_write  out  1  tied 0
- sram_byteenable  out  DATA_W/8  tied all-ones
- sram_clken  out  1  tied 1
- sram_readdata  in  DATA_W  SRAM data, valid the cycle after the strobe
- src_data  out  DATA_W  stream data
- src_valid  out  1  FIFO head valid
- src_ready  in  1  sink accepts the beat when valid & ready
- src_startofpacket  out  1  first beat of the packet
- src_endofpacket  out  1  last beat of the packet

## Operation
- Reset values: busy=0, done=0, sram_chipselect=0, sram_address=0, src_valid=0, src_sop=0, src_eop=0. FIFO and in-flight are empty; state is IDLE.
- IDLE:
  - start with length>0 latches base_addr, length, remaining=length; go to RUN.
  - start with length=0 pulses done in the next cycle; busy stays 0; no beats.
  - start in any other state is ignored.
- RUN: issue a read when remaining>0 and (fifo_count + inflight - pop) < 2.
  - Address increments by 1 per issue, modulo 2^ADDR_W (1023 wraps to 0).
  - Each issue decrements remaining.
  - When remaining reaches 0, go to DRAIN.
- DRAIN: wait until inflight=0 and FIFO is empty, then pulse done and return to IDLE.
- Data capture: the cycle after a strobe, sram_readdata is pushed into the FIFO. The capacity rule guarantees it never overflows.
- Packet flags:
  - SOP is carried with the first word only.
  - EOP is carried with word number length.
  - A single-word packet carries both.
- abort in RUN or DRAIN: next edge flushes the FIFO, discards the in-flight word, drops src_valid, returns to IDLE with busy=0. No done pulse.
- abort in IDLE has no effect. abort has priority over start in the same cycle.
- reset_n low mid-packet: all outputs take reset values asynchronously. No partial packet resumes.

## Timing
- start sampled at edge E. busy=1 and the first strobe are driven in the cycle after E.
- First word is captured at E+2. src_valid is high from E+2 (third cycle counting E's cycle).
- With src_ready held 1: one beat per cycle, so an N-word packet's last beat is accepted at E+N+1 and done pulses in the following cycle.
- Backpressure: while src_ready=0 the FIFO holds at most 2 words and strobes stop. Issue resumes in the same cycle ready returns, with no bubble.
- src_data, src_sop and src_eop are stable while src_valid=1 and src_ready=0.
- busy falls in the same cycle done pulses.

## Test plan
- Reset, then base=0, length=4, ready=1 -> addresses 0,1,2,3 strobed in consecutive cycles; 4 beats back-to-back; SOP on beat 0, EOP on beat 3; done 1 cycle after last accept.
- base=1022, length=4 -> addresses 1022,1023,0,1; data matches preloaded pattern mem[a]=a*0x01010101.
- length=1 -> single beat with SOP=EOP=1. length=0 -> done pulse, no src_valid, busy stays 0.
- length=16 with random src_ready (50%) -> no lost or duplicated words, in order; at most 2 outstanding; data stable under stall.
- abort at beat 5 of 16 -> src_valid 0 next cycle, no done, busy 0; a new start then delivers a clean packet from its own base.
- reset_n asserted mid-packet -> all outputs at reset values immediately; after release, a new start runs normally.
